// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: defaults, FSM states,
// and the redirect-source tag kept alongside the pending target.
package fetch_ctrl_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned MAX_WAIT_DEF    = 15;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_KILL,
    ST_TIMEOUT
  } fetch_state_e;

  typedef enum logic {
    SRC_JUMP   = 1'b0,
    SRC_BRANCH = 1'b1
  } redirect_src_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory req/ack handshake bundle between the fetch sequencer and imem.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
);

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);

endinterface

// File: rtl/fetch_ctrl_watchdog.sv
// Fetch watchdog: counts consecutive unacknowledged request cycles and raises a
// sticky error once MAX_WAIT is reached.
module fetch_watchdog #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic expire,
  output logic timeout
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  // Asserted during the cycle whose edge brings wait_cnt to MAX_WAIT.
  assign expire = count_en && (wait_cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (clear) begin
        wait_cnt <= '0;
      end else if (count_en && (wait_cnt != CW'(MAX_WAIT))) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (expire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-front-end sequencer: owns the PC, runs the imem req/ack handshake and
// arbitrates branch/jump redirects against load-use stalls.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned MAX_WAIT     = MAX_WAIT_DEF,
  parameter bit          NOP_ON_FLUSH = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_addr,
  input  logic                is_jump,
  input  logic [PC_WIDTH-1:0] jump_addr,
  input  logic                load_use_stall,
  fetch_ctrl_if.master        imem,
  output logic [PC_WIDTH-1:0] pc,
  output logic                if_id_valid,
  output logic                stall_if_id,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                flush_ex_mem,
  output logic                fetch_timeout
);

  fetch_state_e        state, state_nx;
  redirect_src_e       pending_src, pending_src_nx;
  logic [PC_WIDTH-1:0] pending_pc, pending_pc_nx;
  logic [PC_WIDTH-1:0] pc_nx;
  logic                req, valid_raw, wd_expire;

  fetch_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (req && !imem.imem_ack),
    .clear    (imem.imem_ack),
    .expire   (wd_expire),
    .timeout  (fetch_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= '0;
      pending_pc  <= '0;
      pending_src <= SRC_JUMP;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      pending_pc  <= pending_pc_nx;
      pending_src <= pending_src_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    pending_pc_nx  = pending_pc;
    pending_src_nx = pending_src;
    req            = 1'b0;
    valid_raw      = 1'b0;
    stall_if_id    = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    flush_ex_mem   = 1'b0;

    unique case (state)
      ST_BOOT: state_nx = ST_FETCH;

      ST_FETCH: begin
        req = 1'b1;
        if (branch_taken) begin
          {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
        end else if (load_use_stall) begin
          stall_if_id = 1'b1;
        end else if (is_jump) begin
          flush_if_id = 1'b1;
        end

        if (imem.imem_ack) begin
          if (branch_taken) begin
            pc_nx = branch_addr;
          end else if (!load_use_stall) begin
            if (is_jump) begin
              pc_nx = jump_addr;
            end else begin
              valid_raw = 1'b1;
              pc_nx     = pc + PC_WIDTH'(1);
            end
          end
        end else if (wd_expire) begin
          state_nx = ST_TIMEOUT;
        end else if (branch_taken) begin
          pending_pc_nx  = branch_addr;
          pending_src_nx = SRC_BRANCH;
          state_nx       = ST_KILL;
        end else if (!load_use_stall && is_jump) begin
          pending_pc_nx  = jump_addr;
          pending_src_nx = SRC_JUMP;
          state_nx       = ST_KILL;
        end
      end

      ST_KILL: begin
        req = 1'b1;
        // A jump seen while a branch is pending sits on the wrong path.
        if (branch_taken) begin
          {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
          pending_pc_nx  = branch_addr;
          pending_src_nx = SRC_BRANCH;
        end else if (load_use_stall) begin
          stall_if_id = 1'b1;
        end else if (is_jump && (pending_src == SRC_JUMP)) begin
          flush_if_id   = 1'b1;
          pending_pc_nx = jump_addr;
        end

        if (imem.imem_ack) begin
          pc_nx    = pending_pc_nx;
          state_nx = ST_FETCH;
        end else if (wd_expire) begin
          state_nx = ST_TIMEOUT;
        end
      end

      ST_TIMEOUT: state_nx = ST_TIMEOUT;

      default: state_nx = ST_BOOT;
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = req ? pc : '0;
  assign if_id_valid    = valid_raw && !(NOP_ON_FLUSH && flush_if_id);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequential fetch, redirects in wait/KILL,
// load-use stalls, watchdog timeout and PC wrap.
module tb_fetch_ctrl;

  localparam int unsigned PCW = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           branch_taken = 1'b0;
  logic           is_jump = 1'b0;
  logic           load_use_stall = 1'b0;
  logic [PCW-1:0] branch_addr = '0;
  logic [PCW-1:0] jump_addr = '0;
  logic [PCW-1:0] pc;
  logic           if_id_valid, stall_if_id;
  logic           flush_if_id, flush_id_ex, flush_ex_mem, fetch_timeout;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  fetch_ctrl_if #(.PC_WIDTH(PCW)) imem ();

  fetch_ctrl #(.PC_WIDTH(PCW), .MAX_WAIT(15), .NOP_ON_FLUSH(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .is_jump        (is_jump),
    .jump_addr      (jump_addr),
    .load_use_stall (load_use_stall),
    .imem           (imem),
    .pc             (pc),
    .if_id_valid    (if_id_valid),
    .stall_if_id    (stall_if_id),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .fetch_timeout  (fetch_timeout)
  );

  always #5 clk = ~clk;

  // Advance to the next cycle, drive inputs on the falling edge, settle.
  task automatic cyc(input logic br, input logic [PCW-1:0] ba, input logic j,
                     input logic [PCW-1:0] ja, input logic st, input logic ack);
    @(negedge clk);
    branch_taken   = br;
    branch_addr    = ba;
    is_jump        = j;
    jump_addr      = ja;
    load_use_stall = st;
    imem.imem_ack  = ack;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem.imem_ack = 1'b0;
    #3;
    n_run++;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_run++;
    if ({imem.imem_req, if_id_valid, stall_if_id, flush_if_id, flush_id_ex, flush_ex_mem, fetch_timeout} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b",
        {imem.imem_req, if_id_valid, stall_if_id, flush_if_id, flush_id_ex, flush_ex_mem, fetch_timeout}, 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_run++;
    if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b expected %b", imem.imem_req, 1'b0); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      n_run++;
      if (imem.imem_addr !== PCW'(i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h expected %h", i, imem.imem_addr, PCW'(i)); end
      n_run++;
      if ({imem.imem_req, if_id_valid} !== 2'b11) begin n_fail++; $display("FAIL seq_valid%0d: got %b expected %b", i, {imem.imem_req, if_id_valid}, 2'b11); end
    end
  endtask

  task automatic test_branch_in_wait();
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_run++;
    if ({if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem} !== 4'b0) begin
      n_fail++; $display("FAIL wait1_quiet: got %b expected %b", {if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem}, 4'b0); end
    cyc(1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
    n_run++;
    if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b111) begin
      n_fail++; $display("FAIL wait2_flush: got %b expected %b", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b111); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if (imem.imem_addr !== 32'h4) begin n_fail++; $display("FAIL kill_addr_held: got %h expected %h", imem.imem_addr, 32'h4); end
    n_run++;
    if ({if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem} !== 4'b0) begin
      n_fail++; $display("FAIL kill_discard: got %b expected %b", {if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem}, 4'b0); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if ({imem.imem_addr, if_id_valid} !== {32'h40, 1'b1}) begin
      n_fail++; $display("FAIL branch_target: got %h/%b expected %h/%b", imem.imem_addr, if_id_valid, 32'h40, 1'b1); end
  endtask

  task automatic test_load_use_stall();
    cyc(1'b1, 32'h10, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if ({if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem} !== 4'b0111) begin
      n_fail++; $display("FAIL ack_branch: got %b expected %b", {if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem}, 4'b0111); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
      n_run++;
      if ({imem.imem_addr, stall_if_id, if_id_valid} !== {32'h10, 2'b10}) begin
        n_fail++; $display("FAIL stall%0d: got %h/%b%b expected %h/%b", i, imem.imem_addr, stall_if_id, if_id_valid, 32'h10, 2'b10); end
    end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if ({imem.imem_addr, stall_if_id, if_id_valid} !== {32'h10, 2'b01}) begin
      n_fail++; $display("FAIL stall_release: got %h/%b%b expected %h/%b", imem.imem_addr, stall_if_id, if_id_valid, 32'h10, 2'b01); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if (imem.imem_addr !== 32'h11) begin n_fail++; $display("FAIL stall_next: got %h expected %h", imem.imem_addr, 32'h11); end
  endtask

  task automatic test_branch_jump_kill();
    cyc(1'b1, 32'h80, 1'b1, 32'h20, 1'b0, 1'b0);
    n_run++;
    if ({imem.imem_addr, flush_if_id, flush_id_ex, flush_ex_mem} !== {32'h12, 3'b111}) begin
      n_fail++; $display("FAIL br_jump_prio: got %h/%b expected %h/%b", imem.imem_addr,
        {flush_if_id, flush_id_ex, flush_ex_mem}, 32'h12, 3'b111); end
    cyc(1'b0, '0, 1'b1, 32'h30, 1'b0, 1'b0);
    n_run++;
    if ({imem.imem_req, imem.imem_addr, flush_if_id} !== {1'b1, 32'h12, 1'b0}) begin
      n_fail++; $display("FAIL kill_wrongpath_jump: got %b/%h/%b expected %b/%h/%b",
        imem.imem_req, imem.imem_addr, flush_if_id, 1'b1, 32'h12, 1'b0); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL kill_ack_valid: got %b expected %b", if_id_valid, 1'b0); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if ({pc, imem.imem_addr, if_id_valid} !== {32'h80, 32'h80, 1'b1}) begin
      n_fail++; $display("FAIL kill_resume: got %h/%h/%b expected %h/%h/%b", pc, imem.imem_addr, if_id_valid, 32'h80, 32'h80, 1'b1); end
  endtask

  task automatic test_jump();
    cyc(1'b0, '0, 1'b1, 32'h200, 1'b0, 1'b1);
    n_run++;
    if ({if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem} !== 4'b0100) begin
      n_fail++; $display("FAIL jump_flush: got %b expected %b", {if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem}, 4'b0100); end
    cyc(1'b0, '0, 1'b1, 32'h300, 1'b1, 1'b1);
    n_run++;
    if ({imem.imem_addr, stall_if_id, flush_if_id} !== {32'h200, 2'b10}) begin
      n_fail++; $display("FAIL jump_under_stall: got %h/%b%b expected %h/%b", imem.imem_addr, stall_if_id, flush_if_id, 32'h200, 2'b10); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if ({imem.imem_addr, if_id_valid} !== {32'h200, 1'b1}) begin
      n_fail++; $display("FAIL jump_refetch: got %h/%b expected %h/%b", imem.imem_addr, if_id_valid, 32'h200, 1'b1); end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 15; k++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      n_run++;
      if ({imem.imem_req, fetch_timeout, imem.imem_addr} !== {2'b10, 32'h201}) begin
        n_fail++; $display("FAIL wait_cycle%0d: got %b%b/%h expected %b/%h", k, imem.imem_req, fetch_timeout, imem.imem_addr, 2'b10, 32'h201); end
    end
    cyc(1'b1, 32'h55, 1'b0, '0, 1'b0, 1'b0);
    n_run++;
    if ({fetch_timeout, imem.imem_req, flush_if_id, flush_id_ex, flush_ex_mem, pc} !== {5'b10000, 32'h201}) begin
      n_fail++; $display("FAIL timeout_state: got %b%b%b%b%b/%h expected %b/%h", fetch_timeout, imem.imem_req,
        flush_if_id, flush_id_ex, flush_ex_mem, pc, 5'b10000, 32'h201); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if ({fetch_timeout, pc} !== {1'b1, 32'h201}) begin
      n_fail++; $display("FAIL timeout_sticky: got %b/%h expected %b/%h", fetch_timeout, pc, 1'b1, 32'h201); end
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({fetch_timeout, pc} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL timeout_reset: got %b/%h expected %b/%h", fetch_timeout, pc, 1'b0, 32'h0); end
    imem.imem_ack = 1'b0;
    branch_taken  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    cyc(1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if (imem.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_setup: got %h expected %h", imem.imem_addr, 32'h0); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if ({imem.imem_addr, if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem} !== {32'hFFFF_FFFF, 4'b1000}) begin
      n_fail++; $display("FAIL wrap_top: got %h/%b expected %h/%b", imem.imem_addr,
        {if_id_valid, flush_if_id, flush_id_ex, flush_ex_mem}, 32'hFFFF_FFFF, 4'b1000); end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_run++;
    if ({pc, imem.imem_addr, if_id_valid} !== {32'h0, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL wrap_zero: got %h/%h/%b expected %h/%h/%b", pc, imem.imem_addr, if_id_valid, 32'h0, 32'h0, 1'b1); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_branch_in_wait();
    test_load_use_stall();
    test_branch_jump_kill();
    test_jump();
    test_timeout();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch front end. It owns the PC register and drives a req/ack instruction-memory handshake with variable latency.
- Arbitrates PC redirects from MEM (taken branch) and ID (jump) against the load-use stall. Generates flush/stall pulses for the pipeline registers.
- Replaces the free-running PC update with a latency-tolerant, redirect-safe controller. Adds a fetch watchdog.

Parameters:
PC_WIDTH, 32, width of PC, branch/jump targets and imem_addr
MAX_WAIT, 15, max consecutive cycles imem_req may be pending without imem_ack before timeout
NOP_ON_FLUSH, 1, 1 = flush pulses also force if_id_valid low in the same cycle

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
branch_taken  in  1  MEM stage: branch resolved taken
branch_addr  in  PC_WIDTH  MEM stage: branch target
is_jump  in  1  ID stage: jump decoded
jump_addr  in  PC_WIDTH  ID stage: jump target
load_use_stall  in  1  hazard unit: hold IF/ID and PC
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_WIDTH  fetch address (equals pc while imem_req=1)
imem_ack  in  1  memory: instruction data valid this cycle
pc  out  PC_WIDTH  current fetch PC
if_id_valid  out  1  load imem data into IF/ID this cycle
stall_if_id  out  1  hold IF/ID contents
flush_if_id  out  1  one-cycle bubble into IF/ID
flush_id_ex  out  1  one-cycle bubble into ID/EX
flush_ex_mem  out  1  one-cycle bubble into EX/MEM
fetch_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n=0, async): pc=0, state=BOOT, wait_cnt=0, pending_pc=0, pending_src=0. All outputs 0.
- BOOT: lasts exactly 1 cycle after rst_n rises, imem_req=0, then FETCH.
- FETCH: imem_req=1, imem_addr=pc. Handshake rule: once imem_req rises with an address, req and addr are held until imem_ack. Zero-wait ack in the same cycle is legal.
- Redirect priority, evaluated per cycle: branch_taken > load_use_stall > is_jump > sequential.
- Branch: target=branch_addr. Pulse flush_if_id, flush_id_ex and flush_ex_mem for 1 cycle.
- Jump: target=jump_addr. Pulse flush_if_id only. A jump is ignored while load_use_stall=1, because the jump stays in ID and is re-presented.
- FETCH with imem_ack:
  - If a redirect occurs: pc<=target, data discarded (if_id_valid=0).
  - Else if load_use_stall: stall_if_id=1, if_id_valid=0, pc unchanged; the same pc is refetched next cycle.
  - Else: if_id_valid=1, pc<=pc+1 (wraps modulo 2^PC_WIDTH).
- FETCH without ack:
  - If a redirect occurs: flush pulses issue now. Latch pending_pc=target, pending_src=branch/jump, go to KILL.
  - If load_use_stall: stall_if_id=1, wait continues.
- KILL: imem_req stays 1 with the old address. On imem_ack, data is discarded, pc<=pending_pc, go to FETCH.
  - A branch during KILL overwrites pending_pc and re-pulses all three flushes.
  - A jump during KILL overwrites only if pending_src=jump. If pending_src=branch the jump is wrong-path and ignored (no flush).
  - If a redirect and imem_ack arrive in the same KILL cycle, the new target is used.
- Watchdog: wait_cnt increments each cycle with imem_req=1 and imem_ack=0. It clears on ack. When wait_cnt reaches MAX_WAIT, go to TIMEOUT.
- TIMEOUT: fetch_timeout=1, imem_req=0, all flushes=0, pc frozen. Exit only by reset.
- stall_if_id and all flushes are combinational from state and inputs. pc, state, wait_cnt and pending_* are registered.
- Reset asserted mid-wait: everything returns to reset values immediately. The memory must tolerate the dropped request.

Decomposition:
- Shared package/defs header: PC_WIDTH default, state encoding (BOOT, FETCH, KILL, TIMEOUT), redirect-source encoding, NOP_INSTRUCTION reuse.
- One natural sub-module: fetch_watchdog, a wait counter with a MAX_WAIT compare and a sticky error flag.

Test Plan:
- Reset then zero-wait ack every cycle -> BOOT 1 cycle, imem_addr 0,1,2,3 on consecutive cycles, if_id_valid=1 each cycle from cycle 2.
- Ack latency 3, branch_taken with branch_addr=0x40 on the 2nd wait cycle -> three flush pulses that cycle, old data discarded at ack, next imem_addr=0x40.
- pc=0x10 acked with load_use_stall=1 for 2 cycles -> stall_if_id=1, if_id_valid=0, imem_addr stays 0x10, then 0x11 after the stall drops.
- Same cycle branch_taken (0x80) and is_jump (0x20) -> pc=0x80, all three flushes. KILL with pending branch then jump 0x30 -> ignored, fetch resumes at 0x80.
- imem_ack held low for MAX_WAIT=15 cycles -> fetch_timeout=1 on cycle 15, imem_req=0, pc frozen; rst_n pulse clears it, pc=0.
- pc=0xFFFFFFFF acked -> pc wraps to 0x00000000, no flush pulses.
